// File: rtl/scr1_pipe_lsu_mo.sv
// Multi-outstanding LSU: pipelines up to OUTSTD DMEM transactions and returns
// results and exceptions to EXU strictly in issue order.
package scr1_lsu_mo_pkg;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned DMEM_AWIDTH = 32;
    localparam int unsigned DMEM_DWIDTH = 32;

    typedef enum logic [3:0] {
        SCR1_LSU_CMD_NONE = 4'd0,
        SCR1_LSU_CMD_LB   = 4'd1,
        SCR1_LSU_CMD_LH   = 4'd2,
        SCR1_LSU_CMD_LW   = 4'd3,
        SCR1_LSU_CMD_LBU  = 4'd4,
        SCR1_LSU_CMD_LHU  = 4'd5,
        SCR1_LSU_CMD_SB   = 4'd6,
        SCR1_LSU_CMD_SH   = 4'd7,
        SCR1_LSU_CMD_SW   = 4'd8
    } type_scr1_lsu_cmd_sel_e;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'd0,
        SCR1_MEM_WIDTH_HWORD = 2'd1,
        SCR1_MEM_WIDTH_WORD  = 2'd2,
        SCR1_MEM_WIDTH_ERROR = 2'd3
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'd0,
        SCR1_MEM_RESP_RDY_OK = 2'd1,
        SCR1_MEM_RESP_RDY_ER = 2'd2
    } type_scr1_mem_resp_e;

    typedef enum logic [3:0] {
        SCR1_EXC_CODE_INSTR_MISALIGN    = 4'd0,
        SCR1_EXC_CODE_INSTR_ACCESS_FAULT = 4'd1,
        SCR1_EXC_CODE_ILLEGAL_INSTR     = 4'd2,
        SCR1_EXC_CODE_BREAKPOINT        = 4'd3,
        SCR1_EXC_CODE_LD_ADDR_MISALIGN  = 4'd4,
        SCR1_EXC_CODE_LD_ACCESS_FAULT   = 4'd5,
        SCR1_EXC_CODE_ST_ADDR_MISALIGN  = 4'd6,
        SCR1_EXC_CODE_ST_ACCESS_FAULT   = 4'd7
    } type_scr1_exc_code_e;
endpackage

module scr1_pipe_lsu_mo
    import scr1_lsu_mo_pkg::*;
#(
    parameter int unsigned OUTSTD     = 2,
    parameter bit          LANE_SHIFT = 1'b1
) (
    input  logic                      rst_n,
    input  logic                      clk,
    input  logic                      exu2lsu_req_i,
    input  type_scr1_lsu_cmd_sel_e    exu2lsu_cmd_i,
    input  logic [XLEN-1:0]           exu2lsu_addr_i,
    input  logic [XLEN-1:0]           exu2lsu_sdata_i,
    output logic                      lsu2exu_req_ack_o,
    output logic                      lsu2exu_rdy_o,
    output logic [XLEN-1:0]           lsu2exu_ldata_o,
    output logic                      lsu2exu_exc_o,
    output type_scr1_exc_code_e       lsu2exu_exc_code_o,
    output logic                      lsu2dmem_req_o,
    output type_scr1_mem_cmd_e        lsu2dmem_cmd_o,
    output type_scr1_mem_width_e      lsu2dmem_width_o,
    output logic [DMEM_AWIDTH-1:0]    lsu2dmem_addr_o,
    output logic [DMEM_DWIDTH-1:0]    lsu2dmem_wdata_o,
    input  logic                      dmem2lsu_req_ack_i,
    input  logic [DMEM_DWIDTH-1:0]    dmem2lsu_rdata_i,
    input  type_scr1_mem_resp_e       dmem2lsu_resp_i,
    output logic                      lsu_busy_o
);
    localparam int unsigned PTR_W = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;
    localparam int unsigned CNT_W = $clog2(OUTSTD + 1);

    type_scr1_lsu_cmd_sel_e fifo_cmd_q [OUTSTD];
    logic [1:0]             fifo_off_q [OUTSTD];
    logic [PTR_W-1:0]       wptr_q, rptr_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q;

    logic                   is_store_s, misalign_s, full_s, empty_s;
    logic                   push_s, pop_s, mis_accept_s;
    type_scr1_mem_width_e   width_s;
    type_scr1_lsu_cmd_sel_e head_cmd_s;
    logic [1:0]             head_off_s;
    logic                   head_store_s;
    logic [XLEN-1:0]        shifted_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUTSTD - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Decode request command into access width and direction
    always_comb begin
        is_store_s = 1'b0;
        width_s    = SCR1_MEM_WIDTH_BYTE;
        case (exu2lsu_cmd_i)
            SCR1_LSU_CMD_LB, SCR1_LSU_CMD_LBU: width_s = SCR1_MEM_WIDTH_BYTE;
            SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LHU: width_s = SCR1_MEM_WIDTH_HWORD;
            SCR1_LSU_CMD_LW:                   width_s = SCR1_MEM_WIDTH_WORD;
            SCR1_LSU_CMD_SB: begin is_store_s = 1'b1; width_s = SCR1_MEM_WIDTH_BYTE;  end
            SCR1_LSU_CMD_SH: begin is_store_s = 1'b1; width_s = SCR1_MEM_WIDTH_HWORD; end
            SCR1_LSU_CMD_SW: begin is_store_s = 1'b1; width_s = SCR1_MEM_WIDTH_WORD;  end
            default:         begin is_store_s = 1'b0; width_s = SCR1_MEM_WIDTH_BYTE;  end
        endcase
    end

    assign misalign_s = ((width_s == SCR1_MEM_WIDTH_HWORD) & exu2lsu_addr_i[0])
                      | ((width_s == SCR1_MEM_WIDTH_WORD) & (exu2lsu_addr_i[1:0] != 2'b00));
    assign full_s     = (cnt_q == CNT_W'(OUTSTD));
    assign empty_s    = (cnt_q == {CNT_W{1'b0}});

    // Misaligned requests wait for an empty FIFO so their exception stays in order
    assign lsu2dmem_req_o    = exu2lsu_req_i & ~misalign_s & ~full_s;
    assign push_s            = lsu2dmem_req_o & dmem2lsu_req_ack_i;
    assign mis_accept_s      = exu2lsu_req_i & misalign_s & empty_s;
    assign lsu2exu_req_ack_o = push_s | mis_accept_s;
    assign pop_s             = ((dmem2lsu_resp_i == SCR1_MEM_RESP_RDY_OK)
                              | (dmem2lsu_resp_i == SCR1_MEM_RESP_RDY_ER)) & ~empty_s;

    assign lsu2dmem_cmd_o   = is_store_s ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    assign lsu2dmem_width_o = width_s;
    assign lsu2dmem_addr_o  = exu2lsu_addr_i;
    assign lsu2dmem_wdata_o = LANE_SHIFT ? (exu2lsu_sdata_i << {exu2lsu_addr_i[1:0], 3'b000})
                                         : exu2lsu_sdata_i;

    assign head_cmd_s   = fifo_cmd_q[rptr_q];
    assign head_off_s   = fifo_off_q[rptr_q];
    assign head_store_s = (head_cmd_s == SCR1_LSU_CMD_SB) | (head_cmd_s == SCR1_LSU_CMD_SH)
                        | (head_cmd_s == SCR1_LSU_CMD_SW);
    assign shifted_s    = LANE_SHIFT ? (dmem2lsu_rdata_i >> {head_off_s, 3'b000}) : dmem2lsu_rdata_i;

    // In-order result: misalign exception or head-of-FIFO response
    always_comb begin
        lsu2exu_rdy_o      = 1'b0;
        lsu2exu_exc_o      = 1'b0;
        lsu2exu_exc_code_o = SCR1_EXC_CODE_INSTR_MISALIGN;
        lsu2exu_ldata_o    = {XLEN{1'b0}};
        if (mis_accept_s) begin
            lsu2exu_rdy_o      = 1'b1;
            lsu2exu_exc_o      = 1'b1;
            lsu2exu_exc_code_o = is_store_s ? SCR1_EXC_CODE_ST_ADDR_MISALIGN
                                            : SCR1_EXC_CODE_LD_ADDR_MISALIGN;
        end else if (pop_s) begin
            lsu2exu_rdy_o = 1'b1;
            if (dmem2lsu_resp_i == SCR1_MEM_RESP_RDY_ER) begin
                lsu2exu_exc_o      = 1'b1;
                lsu2exu_exc_code_o = head_store_s ? SCR1_EXC_CODE_ST_ACCESS_FAULT
                                                  : SCR1_EXC_CODE_LD_ACCESS_FAULT;
            end else begin
                lsu2exu_exc_o = 1'b0;
            end
            case (head_cmd_s)
                SCR1_LSU_CMD_LB:  lsu2exu_ldata_o = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
                SCR1_LSU_CMD_LH:  lsu2exu_ldata_o = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
                SCR1_LSU_CMD_LBU: lsu2exu_ldata_o = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
                SCR1_LSU_CMD_LHU: lsu2exu_ldata_o = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
                SCR1_LSU_CMD_LW:  lsu2exu_ldata_o = shifted_s;
                default:          lsu2exu_ldata_o = {XLEN{1'b0}};
            endcase
        end else begin
            lsu2exu_rdy_o = 1'b0;
        end
    end

    // Occupancy next state; a full FIFO never pushes, so push+pop keeps cnt
    always_comb begin
        cnt_d = cnt_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Tracking FIFO storage, pointers, occupancy and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUTSTD; i++) begin
                fifo_cmd_q[i] <= SCR1_LSU_CMD_NONE;
                fifo_off_q[i] <= 2'b00;
            end
            wptr_q <= {PTR_W{1'b0}};
            rptr_q <= {PTR_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            busy_q <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_cmd_q[wptr_q] <= exu2lsu_cmd_i;
                fifo_off_q[wptr_q] <= exu2lsu_addr_i[1:0];
                wptr_q             <= ptr_inc(wptr_q);
            end
            if (pop_s) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != {CNT_W{1'b0}});
        end
    end

    assign lsu_busy_o = busy_q;
endmodule
